// File: rtl/lu_pkg.sv
// Shared LU definitions: conversion FSM states, default datapath width and
// a helper that builds the most-negative two's complement pattern.
package lu_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DONE
    } state_e;

    localparam int LU_WIDTH = 16;
    localparam int LU_MAX_W = 64;

    // Pattern 1 followed by width-1 zeros, right-aligned in LU_MAX_W bits.
    function automatic logic [LU_MAX_W-1:0] most_neg(input int width);
        logic [LU_MAX_W-1:0] one;
        one = {{(LU_MAX_W-1){1'b0}}, 1'b1};
        return one << (width - 1);
    endfunction

endpackage

// File: rtl/serial_negate_cell.sv
// One bit of the copy-until-first-one-then-invert negation rule.
module serial_negate_cell (
    input  logic b_i,
    input  logic sign_i,
    input  logic seen_one_i,
    output logic r_o,
    output logic seen_one_next_o
);

    // Negative operands invert every bit above the lowest set bit.
    assign r_o             = b_i ^ (sign_i & seen_one_i);
    assign seen_one_next_o = seen_one_i | b_i;

endmodule

// File: rtl/tc_to_signmag_serial.sv
// Bit-serial two's complement to sign-magnitude decoder, LSB-first,
// one bit per clock, with valid/ready handshakes on both sides.
module tc_to_signmag_serial
    import lu_pkg::*;
#(
    parameter int WIDTH = LU_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_sign,
    output logic [WIDTH-1:0] out_mag,
    output logic             out_ovf
);

    localparam int               CW       = $clog2(WIDTH) + 1;
    localparam logic [CW-1:0]    LAST     = CW'(WIDTH - 1);
    localparam logic [WIDTH-1:0] MOST_NEG = WIDTH'(most_neg(WIDTH));

    state_e           state_q, state_d;
    logic [WIDTH-1:0] shift_q, shift_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             seen_q, seen_d;
    logic             sign_q, sign_d;
    logic             out_sign_q, out_sign_d;
    logic [WIDTH-1:0] mag_q, mag_d;
    logic             ovf_q, ovf_d;
    logic             rdy_en_q;

    logic             r;
    logic             seen_nx;
    logic [WIDTH-1:0] res_next;

    serial_negate_cell u_cell (
        .b_i             (shift_q[0]),
        .sign_i          (sign_q),
        .seen_one_i      (seen_q),
        .r_o             (r),
        .seen_one_next_o (seen_nx)
    );

    assign res_next = {r, res_q[WIDTH-1:1]};

    always_comb begin
        state_d    = state_q;
        shift_d    = shift_q;
        res_d      = res_q;
        cnt_d      = cnt_q;
        seen_d     = seen_q;
        sign_d     = sign_q;
        out_sign_d = out_sign_q;
        mag_d      = mag_q;
        ovf_d      = ovf_q;
        case (state_q)
            IDLE: begin
                if (in_valid && rdy_en_q) begin
                    shift_d = in_data;
                    sign_d  = in_data[WIDTH-1];
                    cnt_d   = '0;
                    seen_d  = 1'b0;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                shift_d = shift_q >> 1;
                res_d   = res_next;
                seen_d  = seen_nx;
                cnt_d   = cnt_q + CW'(1);
                // Final bit: publish the result together with the overflow flag.
                if (cnt_q == LAST) begin
                    state_d    = DONE;
                    out_sign_d = sign_q;
                    mag_d      = res_next;
                    ovf_d      = sign_q & (res_next == MOST_NEG);
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            shift_q    <= '0;
            res_q      <= '0;
            cnt_q      <= '0;
            seen_q     <= 1'b0;
            sign_q     <= 1'b0;
            out_sign_q <= 1'b0;
            mag_q      <= '0;
            ovf_q      <= 1'b0;
            rdy_en_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            shift_q    <= shift_d;
            res_q      <= res_d;
            cnt_q      <= cnt_d;
            seen_q     <= seen_d;
            sign_q     <= sign_d;
            out_sign_q <= out_sign_d;
            mag_q      <= mag_d;
            ovf_q      <= ovf_d;
            rdy_en_q   <= 1'b1;
        end
    end

    // in_ready stays low until the first edge after reset release.
    assign in_ready  = rdy_en_q && (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign out_sign  = out_sign_q;
    assign out_mag   = mag_q;
    assign out_ovf   = ovf_q;

endmodule
